dispatch_queue: RTL and testbench
=================================

# dispatch_queue

Transmit side of the rename→issue interface. Buffers renamed instructions from rename, stamps each with a sequential instruction number, and drives `rename_enque`/`rename_issueinfo` into the issue queue whenever it is not halted. Owns the 64-entry physical-register ready table sampled by the issue queue as `busy`:
- Bits are cleared when a producer is dispatched.
- Bits are set by exe/mem broadcasts.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `RESET`  in  1  asynchronous, active-low reset.
- `STALL`  in  1  global stall; freezes FIFO and counter.
- `FLUSH`  in  1  synchronous squash of buffered instructions.
- `rn_valid`  in  1  rename presents an instruction this cycle.
- `rn_issueinfo`  in  170  issue packet; field layout is identical to `rename_issueinfo`.
- `rn_A`, `rn_B`, `rn_C`  in  5 each  architectural register numbers.
- `dq_full`  out  1  back-pressure to rename; `rn_valid` is ignored while high.
- `issue_halt`  in  1  issue queue has no free slot.
- `rename_enque`  out  1  dispatch strobe to issue.
- `rename_instr_num`  out  32  instruction number of the head entry.
- `rename_issueinfo`  out  170  packet of the head entry.
- `rename_A`, `rename_B`, `rename_C`  out  5 each  architectural registers of the head entry.
- `busy`  out  64  physical-register ready vector; 1 = value available.
- `exe_broadcast`, `mem_broadcast`  in  1 each  result broadcasts.
- `exe_broadcast_map`, `mem_broadcast_map`  in  6 each  destination physical register of each broadcast.

## Operation
- **Storage:** DEPTH-entry circular FIFO. Each entry holds {issueinfo, A, B, C, instr_num}. Read/write pointers carry log2(DEPTH)+1 bits, with the extra wrap bit.
  - full = (pointers equal except the MSB).
  - empty = (pointers equal).
- **Enqueue:** on posedge when `rn_valid & !dq_full & !STALL & !FLUSH`.
  - The entry is stamped with `num_ctr`, then `num_ctr` increments.
  - `num_ctr` is 32-bit, wraps 0xFFFFFFFF→0, and resets to 1.
- **Dispatch:** `rename_enque = !empty & !issue_halt & !STALL & !FLUSH`, combinational.
  - Head fields drive the `rename_*` outputs combinationally from the FIFO.
  - When empty, the outputs are zero.
  - The read pointer advances on the posedge where `rename_enque` = 1.
- **No pass-through:** `dq_full` = full, registered-count based. A full FIFO rejects `rn_valid` even if it dispatches in the same cycle.
- **Ready table `rdy[63:0]`:**
  - Reset value is all ones.
  - On each posedge (STALL does not block this), broadcasts set `rdy[exe_map]` and `rdy[mem_map]`.
  - When a dispatch occurs with RegWr_flag (bit 93) = 1 and MapWr (bits 17:12) ≠ 0, `rdy[MapWr]` is cleared. A clear beats a broadcast set to the same index in the same cycle.
  - `rdy[0]` is forced to 1.
- **`busy` bypass:** `busy = rdy | onehot(exe_map if exe_broadcast) | onehot(mem_map if mem_broadcast)`, combinational. A source being woken in the dispatch cycle is therefore seen ready by issue.
- **FLUSH:**
  - Empties the FIFO (pointers ← 0).
  - Sets `rdy` to all ones.
  - Leaves `num_ctr` unchanged, so numbering stays monotonic for the ROB.
  - Rename input is ignored that cycle.
- **Reset (any time, including mid-operation):** pointers 0, `num_ctr` = 1, `rdy` all ones. Outputs then read:
  - `dq_full` 0
  - `rename_enque` 0
  - all `rename_*` 0
  - `busy` all ones (absent broadcasts)

## Timing
- Enqueue at posedge N → entry visible at the head and dispatchable in cycle N+1. Minimum rename→issue latency is 1 cycle.
- Throughput is 1 enqueue + 1 dispatch per cycle.
- `dq_full` updates the cycle after the count reaches DEPTH and falls the cycle after a dispatch.
- `rdy` clear takes effect at the dispatch posedge, and `busy` reflects it from the next cycle.
- A broadcast appears in `busy` in the same cycle (bypass) and is held in `rdy` from the next cycle.
- STALL high: no pointer or counter motion, `rename_enque` = 0, and the head outputs hold.

## Test plan
- **Basic flow:** reset, then enqueue 3 instructions on consecutive cycles with `issue_halt` = 0.
  - `rename_enque` is high on cycles 2–4.
  - `rename_instr_num` reads 1, 2, 3.
  - The FIFO is empty on cycle 5.
- **Back-pressure:** hold `issue_halt` = 1 and enqueue 5 with DEPTH = 4.
  - `dq_full` rises after the 4th accept, and the 5th is not accepted.
  - Release `issue_halt`: dispatch order is 1, 2, 3, 4. `dq_full` drops after the first dispatch.
- **Ready table:** dispatch a packet with RegWr = 1, MapWr = 12.
  - `busy[12]` = 0 next cycle.
  - An `exe_broadcast` of map 12 makes `busy[12]` = 1 combinationally in that cycle and holds it afterwards.
  - MapWr = 0 never clears `busy[0]`.
- **Collision:** in the same cycle, dispatch with MapWr = 7 and `mem_broadcast` map 7 → `busy[7]` = 0 the next cycle.
- **Flush:** with 3 buffered entries and `busy[5]` = 0, pulse FLUSH.
  - Next cycle: FIFO empty, `busy` all ones.
  - The next enqueue gets instr_num 4.
- **Reset mid-stream and stall:**
  - Assert RESET low asynchronously between edges → outputs go to their reset values immediately; the next enqueue gets instr_num 1.
  - STALL for 2 cycles with a full FIFO → no dispatch, while a broadcast still sets `rdy`.

Source files
------------

// File: rtl/dispatch_queue_if.sv
// Rename -> issue handshake bundle for dispatch_queue.
// The slave modport is the dispatch queue's view; the master modport is the
// view of whatever drives rename, issue back-pressure and the broadcasts.
interface dispatch_queue_if;
    // Rename side
    logic         rn_valid;
    logic [169:0] rn_issueinfo;
    logic [4:0]   rn_A;
    logic [4:0]   rn_B;
    logic [4:0]   rn_C;
    logic         dq_full;

    // Issue side
    logic         issue_halt;
    logic         rename_enque;
    logic [31:0]  rename_instr_num;
    logic [169:0] rename_issueinfo;
    logic [4:0]   rename_A;
    logic [4:0]   rename_B;
    logic [4:0]   rename_C;
    logic [63:0]  busy;

    // Result broadcasts from the execution and memory pipes
    logic         exe_broadcast;
    logic         mem_broadcast;
    logic [5:0]   exe_broadcast_map;
    logic [5:0]   mem_broadcast_map;

    modport slave (
        input  rn_valid, rn_issueinfo, rn_A, rn_B, rn_C,
        output dq_full,
        input  issue_halt,
        output rename_enque, rename_instr_num, rename_issueinfo,
        output rename_A, rename_B, rename_C, busy,
        input  exe_broadcast, mem_broadcast, exe_broadcast_map, mem_broadcast_map
    );

    modport master (
        output rn_valid, rn_issueinfo, rn_A, rn_B, rn_C,
        input  dq_full,
        output issue_halt,
        input  rename_enque, rename_instr_num, rename_issueinfo,
        input  rename_A, rename_B, rename_C, busy,
        output exe_broadcast, mem_broadcast, exe_broadcast_map, mem_broadcast_map
    );
endinterface

// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers renamed instructions, stamps them with a sequential
// instruction number, feeds the issue queue from the head, and owns the
// physical-register ready table that issue samples as busy.
module dispatch_queue #(
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             FLUSH,
    dispatch_queue_if.slave  dq
);
    localparam int AW         = $clog2(DEPTH);
    localparam int REGWR_BIT  = 93;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef struct packed {
        logic [169:0] issueinfo;
        logic [4:0]   a;
        logic [4:0]   b;
        logic [4:0]   c;
        logic [31:0]  instr_num;
    } entry_t;

    entry_t      fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] num_ctr;
    logic [63:0] rdy;
    logic [63:0] rdy_next;
    logic [63:0] exe_set;
    logic [63:0] mem_set;
    logic        full;
    logic        empty;
    logic        do_enq;
    logic        do_deq;
    entry_t      head;
    logic [5:0]  head_map;
    logic        head_clr;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);

    // Acceptance looks at the registered fill level only, so a full queue
    // refuses rename even while it dispatches in the same cycle.
    assign do_enq = dq.rn_valid && !full && !STALL && !FLUSH;
    assign do_deq = !empty && !dq.issue_halt && !STALL && !FLUSH;

    assign head     = empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];
    assign head_map = head.issueinfo[17:12];
    assign head_clr = do_deq && head.issueinfo[REGWR_BIT] && (head_map != 6'd0);

    assign dq.dq_full          = full;
    assign dq.rename_enque     = do_deq;
    assign dq.rename_instr_num = head.instr_num;
    assign dq.rename_issueinfo = head.issueinfo;
    assign dq.rename_A         = head.a;
    assign dq.rename_B         = head.b;
    assign dq.rename_C         = head.c;

    assign exe_set = dq.exe_broadcast ? (64'd1 << dq.exe_broadcast_map) : 64'd0;
    assign mem_set = dq.mem_broadcast ? (64'd1 << dq.mem_broadcast_map) : 64'd0;

    // Broadcasts are bypassed so a source woken this cycle is already ready.
    assign dq.busy = rdy | exe_set | mem_set;

    // Entry storage: write the incoming instruction at the tail.
    // NOTE: storage has no reset; empty-state outputs are zeroed by the head
    // mux, so resetting the array would only add reset fan-out.
    always_ff @(posedge CLK) begin
        if (do_enq) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{issueinfo: dq.rn_issueinfo,
                                          a:         dq.rn_A,
                                          b:         dq.rn_B,
                                          c:         dq.rn_C,
                                          instr_num: num_ctr};
        end
    end

    // Pointer and instruction-number update; FLUSH squashes but keeps numbering.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            num_ctr <= 32'd1;
        end else if (FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                num_ctr <= num_ctr + 32'd1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Next ready table: broadcasts set, a dispatching producer clears (clear wins).
    // NOTE: rdy_next takes its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        rdy_next = rdy | exe_set | mem_set;
        if (head_clr) begin
            rdy_next[head_map] = 1'b0;
        end
        rdy_next[0] = 1'b1;
    end

    // Ready table register; STALL does not block broadcasts, FLUSH marks all ready.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rdy <= '1;
        end else if (FLUSH) begin
            rdy <= '1;
        end else begin
            rdy <= rdy_next;
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized bench for dispatch_queue: a behavioural model predicts fill level,
// instruction numbering and the ready table; accepted instructions go into a
// scoreboard that a separate monitor drains whenever the DUT dispatches.
module tb_dispatch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [169:0] info;
        logic [4:0]   a;
        logic [4:0]   b;
        logic [4:0]   c;
        logic [31:0]  num;
    } exp_t;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;

    dispatch_queue_if dq_if ();

    dispatch_queue #(.DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .STALL (stall),
        .FLUSH (flush),
        .dq    (dq_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    exp_t        exp_q [$];
    int          model_cnt;
    logic [31:0] model_num;
    bit          model_rdy [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [169:0] act, input logic [169:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_cnt = 0;
        model_num = 32'd1;
        for (int j = 0; j < 64; j++) model_rdy[j] = 1'b1;
    endtask

    task automatic quiet_inputs();
        dq_if.rn_valid          = 1'b0;
        dq_if.rn_issueinfo      = '0;
        dq_if.rn_A              = '0;
        dq_if.rn_B              = '0;
        dq_if.rn_C              = '0;
        dq_if.issue_halt        = 1'b1;
        dq_if.exe_broadcast     = 1'b0;
        dq_if.mem_broadcast     = 1'b0;
        dq_if.exe_broadcast_map = '0;
        dq_if.mem_broadcast_map = '0;
        stall                   = 1'b0;
        flush                   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dq_full"},      {169'd0, dq_if.dq_full}, 170'd0);
        check({tag, " rename_enque"}, {169'd0, dq_if.rename_enque}, 170'd0);
        check({tag, " instr_num"},    {138'd0, dq_if.rename_instr_num}, 170'd0);
        check({tag, " issueinfo"},    dq_if.rename_issueinfo, 170'd0);
        check({tag, " rename_ABC"},   {155'd0, dq_if.rename_A, dq_if.rename_B, dq_if.rename_C}, 170'd0);
        check({tag, " busy"},         {106'd0, dq_if.busy}, {106'd0, {64{1'b1}}});
    endtask

    // One randomized cycle per iteration; percentages steer the traffic mix.
    task automatic run_cycles(input int n, input int p_valid, input int p_halt,
                              input int p_stall, input int p_flush);
        logic [191:0] wide;
        logic [63:0]  busy_exp;
        bit           rdy_new [64];
        bit           acc;
        bit           disp;
        exp_t         newe;
        exp_t         hd;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) wide[k*32 +: 32] = $urandom;
            dq_if.rn_issueinfo        = wide[169:0];
            dq_if.rn_issueinfo[17:12] = 6'($urandom_range(0, 15));
            dq_if.rn_valid            = ($urandom_range(0, 99) < p_valid);
            dq_if.rn_A                = 5'($urandom);
            dq_if.rn_B                = 5'($urandom);
            dq_if.rn_C                = 5'($urandom);
            dq_if.issue_halt          = ($urandom_range(0, 99) < p_halt);
            stall                     = ($urandom_range(0, 99) < p_stall);
            flush                     = ($urandom_range(0, 99) < p_flush);
            dq_if.exe_broadcast       = ($urandom_range(0, 3) == 0);
            dq_if.mem_broadcast       = ($urandom_range(0, 3) == 0);
            dq_if.exe_broadcast_map   = 6'($urandom_range(0, 15));
            dq_if.mem_broadcast_map   = 6'($urandom_range(0, 15));
            #1;

            disp = (model_cnt > 0) && !dq_if.issue_halt && !stall && !flush;
            acc  = dq_if.rn_valid && (model_cnt < DEPTH) && !stall && !flush;

            for (int j = 0; j < 64; j++) begin
                busy_exp[j] = model_rdy[j]
                    || (dq_if.exe_broadcast && (int'(dq_if.exe_broadcast_map) == j))
                    || (dq_if.mem_broadcast && (int'(dq_if.mem_broadcast_map) == j));
            end
            check("rename_enque", {169'd0, dq_if.rename_enque}, {169'd0, disp});
            check("dq_full", {169'd0, dq_if.dq_full}, {169'd0, (model_cnt == DEPTH)});
            check("busy", {106'd0, dq_if.busy}, {106'd0, busy_exp});
            if (model_cnt == 0) begin
                check("empty instr_num", {138'd0, dq_if.rename_instr_num}, 170'd0);
                check("empty issueinfo", dq_if.rename_issueinfo, 170'd0);
            end

            // Ready table after this edge: sets from broadcasts, then the
            // dispatching producer's clear, with register 0 pinned ready.
            for (int j = 0; j < 64; j++) rdy_new[j] = busy_exp[j];
            if (disp && exp_q.size() > 0) begin
                hd = exp_q[0];
                if (hd.info[93] && hd.info[17:12] != 6'd0) rdy_new[int'(hd.info[17:12])] = 1'b0;
            end
            rdy_new[0] = 1'b1;

            newe.info = dq_if.rn_issueinfo;
            newe.a    = dq_if.rn_A;
            newe.b    = dq_if.rn_B;
            newe.c    = dq_if.rn_C;
            newe.num  = model_num;

            @(posedge clk);
            if (flush) begin
                exp_q.delete();
                model_cnt = 0;
                for (int j = 0; j < 64; j++) model_rdy[j] = 1'b1;
            end else begin
                if (disp) model_cnt--;
                if (acc) begin
                    exp_q.push_back(newe);
                    model_cnt++;
                    model_num = model_num + 32'd1;
                end
                for (int j = 0; j < 64; j++) model_rdy[j] = rdy_new[j];
            end
        end
    endtask

    // Asynchronous reset asserted between edges while traffic is buffered.
    task automatic async_reset_midstream();
        @(negedge clk);
        quiet_inputs();
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: whenever the DUT dispatches, the head must match the oldest
    // expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (dq_if.rename_enque === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dispatch_without_entry: got rename_enque=1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("head instr_num", {138'd0, dq_if.rename_instr_num}, {138'd0, e.num});
                    check("head issueinfo", dq_if.rename_issueinfo, e.info);
                    check("head A", {165'd0, dq_if.rename_A}, {165'd0, e.a});
                    check("head B", {165'd0, dq_if.rename_B}, {165'd0, e.b});
                    check("head C", {165'd0, dq_if.rename_C}, {165'd0, e.c});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        quiet_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_cycles(400, 70, 20,  5, 2);   // mixed traffic
        run_cycles(300, 90, 85, 10, 0);   // mostly full, heavy back-pressure
        run_cycles(300, 30, 10,  0, 1);   // draining
        run_cycles(300, 80, 30, 35, 5);   // stall- and flush-heavy
        async_reset_midstream();
        run_cycles(400, 75, 40, 10, 2);
        async_reset_midstream();
        run_cycles(200, 60, 25,  5, 3);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
